l1ram_rd_streamer: RTL and testbench

//  Read-side controller for the 32x96 L1 line RAM (registered read port, 1-cycle latency).
//  On a start command it walks a range of RAM addresses and presents each word on a

---
 rtl/l1ram_pkg.sv | 14 +
 rtl/l1ram_skid_fifo.sv | 53 +++++
 rtl/l1ram_rd_streamer.sv | 118 +++++++++++
 tb/tb_l1ram_rd_streamer.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1ram_pkg.sv
// l1ram_pkg: shared widths and FSM state encoding for the L1 line RAM
// read streamer and its skid FIFO.
package l1ram_pkg;

  localparam int L1_DATA_W = 96;
  localparam int L1_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } l1_state_e;

endpackage

// File: rtl/l1ram_skid_fifo.sv
// l1ram_skid_fifo: small synchronous FIFO absorbing the RAM read latency.
// Ports: clock, reset (sync, high), push/wdata, pop, rdata (head), empty, count.
module l1ram_skid_fifo #(
  parameter int W = 97,
  parameter int D = 2,
  localparam int PW = (D > 1) ? $clog2(D) : 1,
  localparam int CW = $clog2(D + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [D];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] cnt_q;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(D - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= nxt(wr_q);
      if (pop)  rd_q <= nxt(rd_q);
      if (push && !pop)
        cnt_q <= cnt_q + 1'b1;
      else if (pop && !push)
        cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_q] <= wdata;
  end

  assign rdata = mem[rd_q];
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/l1ram_rd_streamer.sv
// l1ram_rd_streamer: walks an L1 RAM address range and streams words out.
// Ports: clock, reset, start/base_addr/count, busy, done, rdaddress, rd_en, q,
// m_valid, m_ready, m_data, m_last.
module l1ram_rd_streamer
  import l1ram_pkg::*;
#(
  parameter int DATA_W = L1_DATA_W,
  parameter int ADDR_W = L1_ADDR_W,
  parameter int FIFO_D = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rdaddress,
  output logic              rd_en,
  input  logic [DATA_W-1:0] q,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  localparam int CW = $clog2(FIFO_D + 1);

  l1_state_e         state_q;
  l1_state_e         state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   rem_q;
  logic              inflight_q;
  logic              last_q;
  logic              pop;
  logic              issue;
  logic              drained;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_cnt;
  logic [CW:0]       occ;
  logic [DATA_W:0]   head;

  assign pop = !fifo_empty && m_ready;

  // Slots already claimed once this cycle's pop leaves: queued + in flight.
  assign occ = {1'b0, fifo_cnt}
             - {{CW{1'b0}}, pop}
             + {{CW{1'b0}}, inflight_q};

  assign issue = (state_q == ST_ISSUE)
              && (rem_q != '0)
              && (occ < (CW+1)'(FIFO_D));

  assign drained = fifo_empty && !inflight_q;

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_ISSUE;
      ST_ISSUE: if (issue && rem_q == (ADDR_W+1)'(1))
                  state_d = ST_DRAIN;
      ST_DRAIN: if (drained) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q != ST_IDLE);
    done  = (state_q == ST_DRAIN) && drained;
    rd_en = issue;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      inflight_q <= issue;
      last_q     <= issue && (rem_q == (ADDR_W+1)'(1));
      if (state_q == ST_IDLE && start) begin
        addr_q <= base_addr;
        // A zero count selects the whole RAM.
        rem_q  <= (count == '0) ? {1'b1, {ADDR_W{1'b0}}}
                                : {1'b0, count};
      end else if (issue) begin
        addr_q <= addr_q + 1'b1;
        rem_q  <= rem_q - 1'b1;
      end
    end
  end

  l1ram_skid_fifo #(
    .W (DATA_W + 1),
    .D (FIFO_D)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (inflight_q),
    .wdata ({last_q, q}),
    .pop   (pop),
    .rdata (head),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign rdaddress = addr_q;
  assign m_valid   = !fifo_empty;
  assign m_data    = head[DATA_W-1:0];
  assign m_last    = head[DATA_W];

endmodule

// File: tb/tb_l1ram_rd_streamer.sv
// tb_l1ram_rd_streamer: randomized and directed checks of the L1 RAM
// read streamer against a queue-based reference of the expected stream.
module tb_l1ram_rd_streamer;

  localparam int DW = 96;
  localparam int AW = 5;
  localparam int MAXC = 400;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] count;
  logic          busy;
  logic          done;
  logic [AW-1:0] rdaddress;
  logic          rd_en;
  logic [DW-1:0] q;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mem [32];

  logic [DW-1:0] got_data [$];
  logic          got_last [$];
  int            beat_cyc [$];
  logic [AW-1:0] issued [$];
  logic [DW-1:0] exp_data [$];
  logic          exp_last [$];
  logic [AW-1:0] exp_addr [$];
  int            done_cyc;
  int            max_out;
  int            unstable;
  bit            timed_out;
  logic          busy_c0;
  logic          busy_c1;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (rd_en) q <= mem[rdaddress];
  end

  l1ram_rd_streamer dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .rdaddress (rdaddress),
    .rd_en     (rd_en),
    .q         (q),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
  );

  // Reference: the stream a command must produce, from the address rules.
  task automatic ref_build(input logic [AW-1:0] b, input logic [AW-1:0] c);
    int n;
    int a;
    n = (c == 0) ? 32 : int'(c);
    exp_data.delete();
    exp_last.delete();
    exp_addr.delete();
    for (int k = 0; k < n; k++) begin
      a = (int'(b) + k) % 32;
      exp_addr.push_back(a[AW-1:0]);
      exp_data.push_back({3{a}});
      exp_last.push_back(k == n - 1);
    end
  endtask

  // Drives one command and records what the DUT does, cycle by cycle.
  // Cycle 0 is the cycle in which start is presented.
  // mode: 0 ready high, 1 ready 1,0,0 pattern, 2 random, 3 low until hold.
  task automatic run_cmd(input logic [AW-1:0] b, input logic [AW-1:0] c,
                         input int mode, input int hold,
                         input int bs, input int stop);
    logic [DW-1:0] held;
    bit hv;
    int outs;
    int cyc;
    got_data.delete();
    got_last.delete();
    beat_cyc.delete();
    issued.delete();
    done_cyc = -1;
    max_out = 0;
    unstable = 0;
    timed_out = 0;
    hv = 0;
    held = '0;
    outs = 0;
    cyc = 0;
    base_addr = b;
    count = c;
    while (1) begin
      if (cyc > 0) begin
        @(posedge clock);
        #1;
      end
      start = (cyc == 0) || (cyc == bs);
      if (cyc == bs) base_addr = 5'd10;
      case (mode)
        0: m_ready = 1'b1;
        1: m_ready = (cyc % 3 == 0);
        2: m_ready = 1'($urandom_range(0, 1));
        default: m_ready = (cyc >= hold);
      endcase
      #1;
      if (cyc == 0) busy_c0 = busy;
      if (cyc == 1) busy_c1 = busy;
      if (hv && (!m_valid || m_data !== held)) unstable++;
      if (rd_en) begin
        issued.push_back(rdaddress);
        outs++;
      end
      if (m_valid && m_ready) begin
        got_data.push_back(m_data);
        got_last.push_back(m_last);
        beat_cyc.push_back(cyc);
        outs--;
      end
      if (outs > max_out) max_out = outs;
      hv = m_valid && !m_ready;
      held = m_data;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (stop > 0 && got_data.size() == stop) break;
      cyc++;
      if (cyc >= MAXC) begin
        timed_out = 1;
        break;
      end
    end
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    m_ready = 1'b0;
    base_addr = '0;
    count = '0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({busy, done, rdaddress, rd_en, m_valid, m_last} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b/%b/%h/%b/%b/%b req=all zero",
               busy, done, rdaddress, rd_en, m_valid, m_last);
    end
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_basic;
    ref_build(5'd4, 5'd3);
    run_cmd(5'd4, 5'd3, 0, 0, -1, 0);
    checks++;
    if (got_data.size() !== 3) begin
      failures++;
      $display("FAIL basic_len got=%0d req=3", got_data.size());
    end
    foreach (exp_data[i]) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i] ||
          beat_cyc[i] !== 3 + i) begin
        failures++;
        $display("FAIL basic_beat%0d got=%h/%b@%0d req=%h/%b@%0d", i,
                 got_data[i], got_last[i], beat_cyc[i],
                 exp_data[i], exp_last[i], 3 + i);
      end
    end
    checks++;
    if (done_cyc !== 6) begin
      failures++;
      $display("FAIL basic_done got=%0d req=6", done_cyc);
    end
    checks++;
    if (busy_c0 !== 1'b0 || busy_c1 !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_busy got=%b%b%b req=010", busy_c0, busy_c1, busy);
    end
  endtask

  task automatic test_wrap;
    ref_build(5'd30, 5'd0);
    run_cmd(5'd30, 5'd0, 0, 0, -1, 0);
    checks++;
    if (got_data.size() !== 32 || issued.size() !== 32) begin
      failures++;
      $display("FAIL wrap_len got=%0d/%0d req=32", got_data.size(),
               issued.size());
    end
    foreach (exp_data[i]) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i] ||
          issued[i] !== exp_addr[i]) begin
        failures++;
        $display("FAIL wrap_beat%0d got=%h/%b a=%0d req=%h/%b a=%0d", i,
                 got_data[i], got_last[i], issued[i],
                 exp_data[i], exp_last[i], exp_addr[i]);
      end
    end
    checks++;
    if (done_cyc !== 35 || timed_out) begin
      failures++;
      $display("FAIL wrap_done got=%0d req=35", done_cyc);
    end
  endtask

  task automatic test_backpressure;
    ref_build(5'd0, 5'd8);
    run_cmd(5'd0, 5'd8, 1, 0, -1, 0);
    checks++;
    if (got_data.size() !== 8) begin
      failures++;
      $display("FAIL bp_len got=%0d req=8", got_data.size());
    end
    foreach (exp_data[i]) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
        failures++;
        $display("FAIL bp_beat%0d got=%h/%b req=%h/%b", i,
                 got_data[i], got_last[i], exp_data[i], exp_last[i]);
      end
    end
    checks++;
    if (unstable !== 0 || max_out > 2) begin
      failures++;
      $display("FAIL bp_hold got unstable=%0d outstanding=%0d req=0/<=2",
               unstable, max_out);
    end
    checks++;
    if (timed_out || done_cyc !== beat_cyc[$] + 1) begin
      failures++;
      $display("FAIL bp_done got=%0d req=%0d", done_cyc, beat_cyc[$] + 1);
    end
  endtask

  task automatic test_busy_start;
    int bad;
    ref_build(5'd0, 5'd4);
    run_cmd(5'd0, 5'd4, 0, 0, 2, 0);
    checks++;
    if (got_data.size() !== 4 || issued.size() !== 4) begin
      failures++;
      $display("FAIL busy_len got=%0d/%0d req=4", got_data.size(),
               issued.size());
    end
    foreach (exp_data[i]) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
        failures++;
        $display("FAIL busy_beat%0d got=%h/%b req=%h/%b", i,
                 got_data[i], got_last[i], exp_data[i], exp_last[i]);
      end
    end
    checks++;
    if (done_cyc !== 7) begin
      failures++;
      $display("FAIL busy_done got=%0d req=7", done_cyc);
    end
    bad = 0;
    repeat (5) begin
      if (busy || rd_en || m_valid || done) bad++;
      @(posedge clock);
      #1;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL busy_ignored got=%0d active cycles req=0", bad);
    end
  endtask

  task automatic test_reset_mid;
    int bad;
    ref_build(5'd0, 5'd6);
    run_cmd(5'd0, 5'd6, 0, 0, -1, 2);
    checks++;
    if (got_data.size() !== 2 || got_data[1] !== exp_data[1]) begin
      failures++;
      $display("FAIL rst_pre got=%0d beats req=2", got_data.size());
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL rst_flush got v=%b b=%b d=%b req=000",
               m_valid, busy, done);
    end
    bad = 0;
    repeat (8) begin
      @(posedge clock);
      #1;
      if (done || m_valid || rd_en) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL rst_quiet got=%0d active cycles req=0", bad);
    end
    ref_build(5'd1, 5'd1);
    run_cmd(5'd1, 5'd1, 0, 0, -1, 0);
    checks++;
    if (got_data.size() !== 1 || got_data[0] !== exp_data[0] ||
        got_last[0] !== 1'b1 || done_cyc !== 4) begin
      failures++;
      $display("FAIL rst_restart got n=%0d %h/%b d=%0d req 1 %h/1 d=4",
               got_data.size(), got_data[0], got_last[0], done_cyc,
               exp_data[0]);
    end
  endtask

  task automatic test_stall_end;
    ref_build(5'd7, 5'd2);
    run_cmd(5'd7, 5'd2, 3, 9, -1, 0);
    checks++;
    if (issued.size() !== 2 || max_out !== 2 || unstable !== 0) begin
      failures++;
      $display("FAIL stall_fill got rd=%0d out=%0d unst=%0d req 2/2/0",
               issued.size(), max_out, unstable);
    end
    foreach (exp_data[i]) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i] ||
          beat_cyc[i] !== 9 + i) begin
        failures++;
        $display("FAIL stall_beat%0d got=%h/%b@%0d req=%h/%b@%0d", i,
                 got_data[i], got_last[i], beat_cyc[i],
                 exp_data[i], exp_last[i], 9 + i);
      end
    end
    checks++;
    if (done_cyc !== 11) begin
      failures++;
      $display("FAIL stall_done got=%0d req=11", done_cyc);
    end
  endtask

  task automatic test_random;
    logic [AW-1:0] b;
    logic [AW-1:0] c;
    int err;
    for (int t = 0; t < 6; t++) begin
      b = AW'($urandom_range(0, 31));
      c = AW'($urandom_range(0, 31));
      ref_build(b, c);
      run_cmd(b, c, 2, 0, -1, 0);
      err = 0;
      foreach (exp_data[i]) begin
        if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i] ||
            issued[i] !== exp_addr[i]) err++;
      end
      checks++;
      if (got_data.size() !== exp_data.size() || err !== 0) begin
        failures++;
        $display("FAIL rand%0d_stream b=%0d c=%0d got n=%0d err=%0d req n=%0d",
                 t, b, c, got_data.size(), err, exp_data.size());
      end
      checks++;
      if (unstable !== 0 || max_out > 2) begin
        failures++;
        $display("FAIL rand%0d_flow got unst=%0d out=%0d req 0/<=2",
                 t, unstable, max_out);
      end
      checks++;
      if (timed_out || done_cyc !== beat_cyc[$] + 1) begin
        failures++;
        $display("FAIL rand%0d_done got=%0d req=%0d", t, done_cyc,
                 beat_cyc[$] + 1);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = {3{i}};
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_busy_start();
    test_reset_mid();
    test_stall_end();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
